// File: rtl/vga_cfg_axil_regs.sv
// AXI4-Lite register slave for VGA configuration: drives resolution/request into vga_clk_gen
// and tracks its completion pulse through a sticky done / busy status pair.
package vga_cfg_pkg;
  typedef enum logic {
    VGA_RES_800_600   = 1'b0,
    VGA_RES_1280_1024 = 1'b1
  } vga_resolution_e;
endpackage

module vga_cfg_axil_regs
  import vga_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_100m_i,
  input  logic                  arstn_i,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output vga_resolution_e       resolution_o,
  output logic                  req_o,
  input  logic                  valid_i
);

  localparam int unsigned IdxW  = ADDR_W - 2;
  localparam int unsigned StrbW = DATA_W / 8;

  localparam logic [IdxW-1:0] IdxCtrl    = IdxW'(0);
  localparam logic [IdxW-1:0] IdxStatus  = IdxW'(1);
  localparam logic [IdxW-1:0] IdxScratch = IdxW'(2);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Write address / data buffers, one deep each
  logic              r_aw_full;
  logic [IdxW-1:0]   r_aw_idx;
  logic              r_w_full;
  logic [DATA_W-1:0] r_w_data;
  logic [StrbW-1:0]  r_w_strb;

  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  vga_resolution_e   r_res;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_scratch;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;
  logic              w_wr_hit;
  logic              w_wr_ctrl;
  logic              w_wr_scr;
  logic              w_ctrl_en;
  logic              w_req_start;
  logic [DATA_W-1:0] w_scratch_d;
  logic [IdxW-1:0]   w_ar_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_err;
  logic              w_unused_addr;

  assign w_unused_addr = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ~r_aw_full;
  assign s_axi_wready  = ~r_w_full;
  assign s_axi_arready = ~r_rvalid;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign resolution_o  = r_res;
  assign req_o         = r_req;

  assign w_aw_hs  = s_axi_awvalid & ~r_aw_full;
  assign w_w_hs   = s_axi_wvalid & ~r_w_full;
  assign w_ar_hs  = s_axi_arvalid & ~r_rvalid;
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

  assign w_wr_hit  = (r_aw_idx == IdxCtrl) || (r_aw_idx == IdxStatus) ||
                     (r_aw_idx == IdxScratch);
  assign w_wr_ctrl = w_commit & (r_aw_idx == IdxCtrl);
  assign w_wr_scr  = w_commit & (r_aw_idx == IdxScratch);

  // CTRL is frozen while a reconfiguration is outstanding
  assign w_ctrl_en   = w_wr_ctrl & r_w_strb[0] & ~r_busy;
  assign w_req_start = w_ctrl_en & r_w_data[1];

  always_comb begin
    w_scratch_d = r_scratch;
    for (int k = 0; k < StrbW; k++) begin
      if (r_w_strb[k]) begin
        w_scratch_d[8*k +: 8] = r_w_data[8*k +: 8];
      end
    end
  end

  assign w_ar_idx = s_axi_araddr[ADDR_W-1:2];

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_ar_idx)
      IdxCtrl:    w_rd_data[0]   = r_res;
      IdxStatus:  w_rd_data[1:0] = {r_busy, r_done};
      IdxScratch: w_rd_data      = r_scratch;
      default:    w_rd_err       = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
    end else if (w_aw_hs) begin
      r_aw_full <= 1'b1;
      r_aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else if (w_w_hs) begin
      r_w_full <= 1'b1;
      r_w_data <= s_axi_wdata;
      r_w_strb <= s_axi_wstrb;
    end else if (w_commit) begin
      r_w_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RespOkay;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_hit ? RespOkay : RespSlverr;
    end else if (r_bvalid && s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RespOkay;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_err ? RespSlverr : RespOkay;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_100m_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_res     <= VGA_RES_800_600;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scratch <= '0;
    end else begin
      r_req <= w_req_start;
      if (w_ctrl_en) begin
        r_res <= vga_resolution_e'(r_w_data[0]);
      end
      // Start and completion are exclusive: a start needs busy=0, completion needs busy=1
      if (w_req_start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (r_busy && valid_i) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_wr_scr) begin
        r_scratch <= w_scratch_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_cfg_axil_regs.sv
// Directed bench for vga_cfg_axil_regs with a transaction-level register model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_vga_cfg_axil_regs;
  import vga_cfg_pkg::*;

  logic        clk;
  logic        arstn;
  logic [10:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [10:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  vga_resolution_e res_o;
  logic        req_o;
  logic        valid_i;

  int n_checks = 0;
  int n_errors = 0;
  int req_pulses = 0;

  vga_cfg_axil_regs #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk_100m_i    (clk),
    .arstn_i       (arstn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .resolution_o  (res_o),
    .req_o         (req_o),
    .valid_i       (valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register model ----------------
  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t         wr_q[$];
  logic [10:0] rd_q[$];
  logic        m_res, m_busy, m_done;
  logic [31:0] m_scratch;

  function automatic void model_read(input logic [10:0] a, output logic [31:0] d,
                                     output logic [1:0] r);
    d = 32'h0;
    r = 2'b00;
    case (a >> 2)
      11'd0:   d = {31'h0, m_res};
      11'd1:   d = {30'h0, m_busy, m_done};
      11'd2:   d = m_scratch;
      default: r = 2'b10;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] ed;
    logic [1:0]  er;
    logic        exp_req, old_busy, prev_b, prev_r, pend_valid;
    wr_t         w;
    logic [10:0] ra;
    if (!arstn) begin
      m_res = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_scratch = 32'h0;
      wr_q.delete(); rd_q.delete();
      prev_b = 1'b0; prev_r = 1'b0; pend_valid = 1'b0;
    end else begin
      // A read returns the register state from before the edge that accepted it
      if (s_axi_rvalid && !prev_r) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_r", 32'h1, 32'h0);
        end else begin
          ra = rd_q.pop_front();
          model_read(ra, ed, er);
          chk("rdata", s_axi_rdata, ed);
          chk("rresp", {30'h0, s_axi_rresp}, {30'h0, er});
        end
      end
      exp_req  = 1'b0;
      old_busy = m_busy;
      if (s_axi_bvalid && !prev_b) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_b", 32'h1, 32'h0);
        end else begin
          w = wr_q.pop_front();
          er = 2'b00;
          case (w.a >> 2)
            11'd0: begin
              if (w.s[0] && !old_busy) begin
                m_res = w.d[0];
                if (w.d[1]) begin
                  m_busy = 1'b1; m_done = 1'b0; exp_req = 1'b1;
                end
              end
            end
            11'd1: ;
            11'd2: begin
              for (int k = 0; k < 4; k++)
                if (w.s[k]) m_scratch[8*k +: 8] = w.d[8*k +: 8];
            end
            default: er = 2'b10;
          endcase
          chk("bresp", {30'h0, s_axi_bresp}, {30'h0, er});
        end
      end
      if (pend_valid && old_busy) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
      chk("req_o", {31'h0, req_o}, {31'h0, exp_req});
      chk("resolution_o", {31'h0, res_o}, {31'h0, m_res});
      chk("arready", {31'h0, s_axi_arready}, {31'h0, !s_axi_rvalid});
      if (req_o) req_pulses++;
      pend_valid = valid_i;
      prev_b = s_axi_bvalid;
      prev_r = s_axi_rvalid;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    logic aw_ok, w_ok, a_r, w_r, got;
    int   n, m;
    wr_q.push_back('{a, d, s});
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      a_r = s_axi_awready; w_r = s_axi_wready;
      tick();
      n++;
      if (s_axi_awvalid && a_r) begin aw_ok = 1'b1; s_axi_awvalid = 1'b0; end
      if (s_axi_wvalid && w_r) begin w_ok = 1'b1; s_axi_wvalid = 1'b0; end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    got = 1'b0; m = 0;
    while (!got && m < 20) begin
      @(negedge clk);
      if (s_axi_bvalid) got = 1'b1;
      else begin tick(); m++; end
    end
    if (!got) chk("b_timeout", 32'h0, 32'h1);
    resp = s_axi_bresp;
    lat = n + m;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [10:0] a, output logic [31:0] d, output logic [1:0] r);
    logic ok, got;
    int   n;
    rd_q.push_back(a);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = s_axi_arready;
      tick();
      n++;
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (s_axi_rvalid) got = 1'b1;
      else begin tick(); n++; end
    end
    if (!got) chk("r_timeout", 32'h0, 32'h1);
    d = s_axi_rdata; r = s_axi_rresp;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic pulse_valid();
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    arstn = 1'b0; valid_i = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", {31'h0, s_axi_awready}, 32'h1);
    chk("rst_wready", {31'h0, s_axi_wready}, 32'h1);
    chk("rst_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
    arstn = 1'b1;
    tick();

    axi_read(11'h004, d, r);
    chk("status_after_reset", d, 32'h0);
    chk("status_rresp", {30'h0, r}, 32'h0);
    axi_read(11'h000, d, r);
    chk("ctrl_after_reset", d, 32'h0);
    chk("res_after_reset", {31'h0, res_o}, 32'h0);

    // Reconfiguration request
    axi_write(11'h000, 32'h3, 4'hF, r, lat);
    chk("req_bresp", {30'h0, r}, 32'h0);
    chk("best_case_latency", lat, 32'd2);
    chk("req_pulse_count", req_pulses, 32'd1);
    chk("res_1280", {31'h0, res_o}, 32'h1);
    axi_read(11'h004, d, r);
    chk("status_busy", d, 32'h2);

    // CTRL writes while busy are ignored
    axi_write(11'h000, 32'h2, 4'hF, r, lat);
    chk("busy_wr_bresp", {30'h0, r}, 32'h0);
    axi_write(11'h000, 32'h0, 4'hF, r, lat);
    chk("busy_no_req", req_pulses, 32'd1);
    chk("busy_res_stable", {31'h0, res_o}, 32'h1);

    pulse_valid();
    axi_read(11'h004, d, r);
    chk("status_done", d, 32'h1);
    pulse_valid();
    axi_read(11'h004, d, r);
    chk("status_valid_ignored", d, 32'h1);

    // No byte-0 strobe: CTRL untouched; STATUS write ignored
    axi_write(11'h000, 32'h0, 4'hE, r, lat);
    chk("ctrl_nostrb_res", {31'h0, res_o}, 32'h1);
    axi_write(11'h004, 32'hFFFF_FFFF, 4'hF, r, lat);
    chk("status_wr_bresp", {30'h0, r}, 32'h0);
    axi_read(11'h004, d, r);
    chk("status_ro", d, 32'h1);

    // Byte strobes and unmapped address
    axi_write(11'h008, 32'h0, 4'hF, r, lat);
    axi_write(11'h008, 32'hDEAD_BEEF, 4'h5, r, lat);
    axi_read(11'h008, d, r);
    chk("scratch_strb", d, 32'h00AD_00EF);
    axi_write(11'h010, 32'h1234_5678, 4'hF, r, lat);
    chk("bad_bresp", {30'h0, r}, 32'h2);
    axi_read(11'h010, d, r);
    chk("bad_rdata", d, 32'h0);
    chk("bad_rresp", {30'h0, r}, 32'h2);

    // AW leads W by 3 cycles; B held off while a second write is buffered
    wr_q.push_back('{11'h008, 32'h1111_2222, 4'hF});
    s_axi_awaddr = 11'h008; s_axi_awvalid = 1'b1;
    @(negedge clk);
    chk("aw1_ready", {31'h0, s_axi_awready}, 32'h1);
    tick();
    s_axi_awvalid = 1'b0;
    tick(); tick();
    s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    chk("aw1_held_awready", {31'h0, s_axi_awready}, 32'h0);
    chk("bvalid_before_w", {31'h0, s_axi_bvalid}, 32'h0);
    tick();
    s_axi_wvalid = 1'b0;
    tick();
    wr_q.push_back('{11'h008, 32'h3333_4444, 4'hF});
    s_axi_awaddr = 11'h008; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h3333_4444; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold", {31'h0, s_axi_bvalid}, 32'h1);
      if (i == 1) begin
        chk("aw2_buffered", {31'h0, s_axi_awready}, 32'h0);
        chk("w2_buffered", {31'h0, s_axi_wready}, 32'h0);
      end
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    @(negedge clk);
    chk("b_gap", {31'h0, s_axi_bvalid}, 32'h0);
    @(negedge clk);
    chk("b2_valid", {31'h0, s_axi_bvalid}, 32'h1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    axi_read(11'h008, d, r);
    chk("scratch_second", d, 32'h3333_4444);

    // Reset with both responses pending
    wr_q.push_back('{11'h008, 32'hAAAA_5555, 4'hF});
    rd_q.push_back(11'h000);
    s_axi_awaddr = 11'h008; s_axi_wdata = 32'hAAAA_5555; s_axi_wstrb = 4'hF;
    s_axi_araddr = 11'h000;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    @(negedge clk);
    chk("pre_rst_bvalid", {31'h0, s_axi_bvalid}, 32'h1);
    chk("pre_rst_rvalid", {31'h0, s_axi_rvalid}, 32'h1);
    #2 arstn = 1'b0;
    #1;
    chk("arst_bvalid", {31'h0, s_axi_bvalid}, 32'h0);
    chk("arst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
    chk("arst_ready", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
    chk("arst_res", {31'h0, res_o}, 32'h0);
    chk("arst_rdata", s_axi_rdata, 32'h0);
    tick(); tick();
    arstn = 1'b1;
    tick();
    axi_read(11'h000, d, r);
    chk("post_rst_ctrl", d, 32'h0);
    axi_read(11'h004, d, r);
    chk("post_rst_status", d, 32'h0);
    axi_read(11'h008, d, r);
    chk("post_rst_scratch", d, 32'h0);

    repeat (2) tick();
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
